// File: rtl/textmode_spi_host.sv
// SPI master for the text-mode board write port: scroll, address, then streamed data.
// Each byte takes 16*CLK_DIV clk cycles; header bytes run back to back.
// Data is pulled with a valid/ready handshake; SCK and SSEL stay low while no data is offered.
module textmode_spi_host #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        scroll_only,
  input  logic [6:0]  scroll,
  input  logic [14:0] addr,
  input  logic [7:0]  data_in,
  input  logic        data_last,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  miso_byte,
  output logic        miso_valid,
  output logic        SCK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        SSEL
);

  typedef enum logic [2:0] {IDLE, SHIFT, WAIT_DATA, HOLD, GAP} state_t;

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int GW = (CS_GAP < 1) ? 1 : $clog2(CS_GAP + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP);

  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [GW-1:0] gap_q;
  logic [2:0]    bit_q;
  logic [1:0]    byte_q;       // 0 scroll, 1 addr high, 2 addr low, 3 data
  logic [7:0]    tx_q;         // tx_q[7] is always the bit on MOSI
  logic [7:0]    rx_q;
  logic [14:0]   addr_q;
  logic          scroll_only_q;
  logic          last_q;
  logic          sck_q, mosi_q, ssel_q;
  logic          busy_q, done_q, data_ready_q;
  logic [7:0]    miso_byte_q;
  logic          miso_valid_q;
  logic          div_end;

  assign div_end = (div_q == DIV_LAST);

  // Transaction sequencer: owns every output register so all outputs are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      div_q         <= '0;
      gap_q         <= '0;
      bit_q         <= 3'd7;
      byte_q        <= 2'd0;
      tx_q          <= 8'h00;
      rx_q          <= 8'h00;
      addr_q        <= 15'h0000;
      scroll_only_q <= 1'b0;
      last_q        <= 1'b0;
      sck_q         <= 1'b0;
      mosi_q        <= 1'b0;
      ssel_q        <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      data_ready_q  <= 1'b0;
      miso_byte_q   <= 8'h00;
      miso_valid_q  <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      miso_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q        <= addr;
            scroll_only_q <= scroll_only;
            tx_q          <= {1'b0, scroll};
            mosi_q        <= 1'b0;
            ssel_q        <= 1'b0;
            sck_q         <= 1'b0;
            busy_q        <= 1'b1;
            byte_q        <= 2'd0;
            bit_q         <= 3'd7;
            div_q         <= '0;
            state_q       <= SHIFT;
          end
        end
        SHIFT: begin
          if (!div_end) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            if (!sck_q) begin
              // Rising SCK: MISO has been stable since the previous falling edge.
              sck_q <= 1'b1;
              rx_q  <= {rx_q[6:0], MISO};
            end else begin
              sck_q <= 1'b0;
              if (bit_q != 3'd0) begin
                bit_q  <= bit_q - 3'd1;
                tx_q   <= {tx_q[6:0], 1'b0};
                mosi_q <= tx_q[6];
              end else begin
                bit_q        <= 3'd7;
                miso_byte_q  <= rx_q;
                miso_valid_q <= 1'b1;
                case (byte_q)
                  2'd0: begin
                    if (scroll_only_q) begin
                      state_q <= HOLD;
                    end else begin
                      tx_q   <= {1'b0, addr_q[14:8]};
                      mosi_q <= 1'b0;
                      byte_q <= 2'd1;
                    end
                  end
                  2'd1: begin
                    tx_q   <= addr_q[7:0];
                    mosi_q <= addr_q[7];
                    byte_q <= 2'd2;
                  end
                  2'd2: begin
                    byte_q       <= 2'd3;
                    data_ready_q <= 1'b1;
                    state_q      <= WAIT_DATA;
                  end
                  default: begin
                    if (last_q) begin
                      state_q <= HOLD;
                    end else begin
                      data_ready_q <= 1'b1;
                      state_q      <= WAIT_DATA;
                    end
                  end
                endcase
              end
            end
          end
        end
        WAIT_DATA: begin
          // The slave is edge-driven, so the stall may last indefinitely.
          if (data_valid && data_ready_q) begin
            tx_q         <= data_in;
            last_q       <= data_last;
            mosi_q       <= data_in[7];
            data_ready_q <= 1'b0;
            bit_q        <= 3'd7;
            div_q        <= '0;
            state_q      <= SHIFT;
          end
        end
        HOLD: begin
          if (div_end) begin
            div_q   <= '0;
            ssel_q  <= 1'b1;
            gap_q   <= '0;
            state_q <= GAP;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign SCK        = sck_q;
  assign MOSI       = mosi_q;
  assign SSEL       = ssel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign data_ready = data_ready_q;
  assign miso_byte  = miso_byte_q;
  assign miso_valid = miso_valid_q;

endmodule

// File: tb/tb_textmode_spi_host.sv
// Directed bench: two hosts (CLK_DIV=4 and CLK_DIV=1) share one text-mode slave model;
// sel chooses which host the slave listens to. Only the selected host ever gets start.
module tb_textmode_spi_host;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        sel;
  logic        start, scroll_only, data_last, data_valid;
  logic [6:0]  scroll;
  logic [14:0] addr;
  logic [7:0]  data_in;
  logic        miso;

  logic [1:0]      start_w, data_ready_w, busy_w, done_w, miso_valid_w, sck_w, mosi_w, ssel_w;
  logic [1:0][7:0] miso_byte_w;

  assign start_w = {start & sel, start & ~sel};

  textmode_spi_host #(.CLK_DIV(4), .CS_GAP(2)) u_div4 (
    .clk(clk), .rst(rst), .start(start_w[0]), .scroll_only(scroll_only), .scroll(scroll),
    .addr(addr), .data_in(data_in), .data_last(data_last), .data_valid(data_valid),
    .data_ready(data_ready_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .miso_byte(miso_byte_w[0]), .miso_valid(miso_valid_w[0]),
    .SCK(sck_w[0]), .MOSI(mosi_w[0]), .MISO(miso), .SSEL(ssel_w[0]));

  textmode_spi_host #(.CLK_DIV(1), .CS_GAP(2)) u_div1 (
    .clk(clk), .rst(rst), .start(start_w[1]), .scroll_only(scroll_only), .scroll(scroll),
    .addr(addr), .data_in(data_in), .data_last(data_last), .data_valid(data_valid),
    .data_ready(data_ready_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .miso_byte(miso_byte_w[1]), .miso_valid(miso_valid_w[1]),
    .SCK(sck_w[1]), .MOSI(mosi_w[1]), .MISO(miso), .SSEL(ssel_w[1]));

  logic       sck_m, mosi_m, ssel_m, busy_m, done_m, data_ready_m, miso_valid_m;
  logic [7:0] miso_byte_m;
  assign sck_m        = sck_w[sel];
  assign mosi_m       = mosi_w[sel];
  assign ssel_m       = ssel_w[sel];
  assign busy_m       = busy_w[sel];
  assign done_m       = done_w[sel];
  assign data_ready_m = data_ready_w[sel];
  assign miso_valid_m = miso_valid_w[sel];
  assign miso_byte_m  = miso_byte_w[sel];

  // Slave model: mode 0, returns 0xA0 every byte, decodes scroll/addr/data and auto-increments.
  logic [7:0]  slv_tx = 8'hA0;
  logic [2:0]  obit = 3'd7;
  logic [7:0]  rx_s;
  logic [14:0] saddr;
  int          bitn, nbytes, sck_rises, mv_cnt;
  time         rise_t, prev_rise_t;
  logic [7:0]  wire_q[$];
  logic [7:0]  char_mem[16384];
  logic [7:0]  attr_mem[16384];

  assign miso = slv_tx[obit];

  always @(posedge sck_m or negedge sck_m or posedge ssel_m) begin
    if (ssel_m !== 1'b0) begin
      obit = 3'd7; bitn = 0; nbytes = 0;
    end else if (sck_m === 1'b1) begin
      prev_rise_t = rise_t; rise_t = $time; sck_rises++;
      rx_s = {rx_s[6:0], mosi_m}; bitn++;
      if (bitn == 8) begin
        bitn = 0;
        wire_q.push_back(rx_s);
        case (nbytes)
          0: ;
          1: saddr[14:8] = rx_s[6:0];
          2: saddr[7:0] = rx_s;
          default: begin
            if (saddr[0]) attr_mem[saddr[14:1]] = rx_s;
            else          char_mem[saddr[14:1]] = rx_s;
            saddr = saddr + 15'd1;
          end
        endcase
        nbytes++;
      end
    end else begin
      obit = obit - 3'd1;
    end
  end

  always @(posedge clk) if (miso_valid_m === 1'b1) mv_cnt++;

  task automatic kick(input bit so, input logic [6:0] sc, input logic [14:0] ad);
    @(negedge clk); scroll_only = so; scroll = sc; addr = ad; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (data_ready_m === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done_m === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic push(input logic [7:0] d, input bit last, output bit ok);
    wait_ready(ok);
    if (ok) begin
      data_in = d; data_last = last; data_valid = 1'b1;
      @(negedge clk); data_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (ssel_m !== 1'b1) begin errors++; $display("FAIL reset_ssel: got %b want 1", ssel_m); end
    checks++; if (sck_m !== 1'b0 || mosi_m !== 1'b0) begin errors++; $display("FAIL reset_sck_mosi: got %b%b want 00", sck_m, mosi_m); end
    checks++; if ({busy_m, done_m, data_ready_m, miso_valid_m} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {busy_m, done_m, data_ready_m, miso_valid_m}); end
    checks++; if (miso_byte_m !== 8'h00) begin errors++; $display("FAIL reset_miso_byte: got %h want 00", miso_byte_m); end
    checks++; if (ssel_w[1] !== 1'b1 || sck_w[1] !== 1'b0) begin errors++; $display("FAIL reset_div1: got ssel=%b sck=%b want 1 0", ssel_w[1], sck_w[1]); end
    rst = 1'b0;
  endtask

  task automatic test_scroll_only;
    int wb, rb, mb, low, gap;
    wb = wire_q.size(); rb = sck_rises; mb = mv_cnt;
    kick(1'b1, 7'h15, 15'h0000);
    low = 0;
    for (int i = 0; i < 400; i++) begin
      if (ssel_m !== 1'b0) break;
      low++;
      @(negedge clk);
    end
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); gap++;
      if (done_m === 1'b1) break;
    end
    checks++; if (low != 68) begin errors++; $display("FAIL so_ssel_low: got %0d want 68", low); end
    checks++; if (gap != 3) begin errors++; $display("FAIL so_done_delay: got %0d want 3", gap); end
    checks++; if (sck_rises - rb != 8) begin errors++; $display("FAIL so_sck_pulses: got %0d want 8", sck_rises - rb); end
    checks++; if (wire_q.size() - wb != 1) begin errors++; $display("FAIL so_byte_count: got %0d want 1", wire_q.size() - wb); end
    else begin checks++; if (wire_q[wb] !== 8'h15) begin errors++; $display("FAIL so_byte: got %h want 15", wire_q[wb]); end end
    checks++; if (miso_byte_m !== 8'hA0) begin errors++; $display("FAIL so_miso_byte: got %h want a0", miso_byte_m); end
    checks++; if (mv_cnt - mb != 1) begin errors++; $display("FAIL so_miso_valid: got %0d want 1", mv_cnt - mb); end
    @(negedge clk);
    checks++; if (done_m !== 1'b0 || busy_m !== 1'b0) begin errors++; $display("FAIL so_after_done: got done=%b busy=%b want 0 0", done_m, busy_m); end
  endtask

  task automatic test_write;
    int wb, mb; bit ok; logic [7:0] exp[$];
    wb = wire_q.size(); mb = mv_cnt;
    kick(1'b0, 7'h7F, 15'h1234);
    push(8'h41, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_ready1: got timeout want data_ready"); end
    checks++; if (data_ready_m !== 1'b0 || busy_m !== 1'b1) begin errors++; $display("FAIL write_after_hs: got ready=%b busy=%b want 0 1", data_ready_m, busy_m); end
    push(8'h1E, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_ready2: got timeout want data_ready"); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_done: got timeout want done"); end
    exp = '{8'h7F, 8'h12, 8'h34, 8'h41, 8'h1E};
    checks++; if (wire_q.size() - wb != exp.size()) begin errors++; $display("FAIL write_count: got %0d want %0d", wire_q.size() - wb, exp.size()); end
    foreach (exp[i]) if (wb + i < wire_q.size()) begin
      checks++; if (wire_q[wb+i] !== exp[i]) begin errors++; $display("FAIL write_byte%0d: got %h want %h", i, wire_q[wb+i], exp[i]); end
    end
    checks++; if (char_mem[14'h091A] !== 8'h41) begin errors++; $display("FAIL write_char: got %h want 41", char_mem[14'h091A]); end
    checks++; if (attr_mem[14'h091A] !== 8'h1E) begin errors++; $display("FAIL write_attr: got %h want 1e", attr_mem[14'h091A]); end
    checks++; if (mv_cnt - mb != 5) begin errors++; $display("FAIL write_miso_valid: got %0d want 5", mv_cnt - mb); end
  endtask

  task automatic test_stall;
    int wb, rb, bad; bit ok; logic [7:0] exp[$];
    wb = wire_q.size(); rb = sck_rises;
    kick(1'b0, 7'h01, 15'h0100);
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_ready: got timeout want data_ready"); end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sck_m !== 1'b0 || ssel_m !== 1'b0 || data_ready_m !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_lines: got %0d bad cycles want 0", bad); end
    checks++; if (sck_rises - rb != 24) begin errors++; $display("FAIL stall_rises: got %0d want 24", sck_rises - rb); end
    push(8'h55, 1'b1, ok);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_done: got timeout want done"); end
    exp = '{8'h01, 8'h01, 8'h00, 8'h55};
    checks++; if (wire_q.size() - wb != exp.size()) begin errors++; $display("FAIL stall_count: got %0d want %0d", wire_q.size() - wb, exp.size()); end
    foreach (exp[i]) if (wb + i < wire_q.size()) begin
      checks++; if (wire_q[wb+i] !== exp[i]) begin errors++; $display("FAIL stall_byte%0d: got %h want %h", i, wire_q[wb+i], exp[i]); end
    end
    checks++; if (char_mem[14'h0080] !== 8'h55) begin errors++; $display("FAIL stall_char: got %h want 55", char_mem[14'h0080]); end
  endtask

  task automatic test_start_busy;
    int wb; bit ok; logic [7:0] exp[$];
    wb = wire_q.size();
    kick(1'b0, 7'h33, 15'h0404);
    repeat (20) @(negedge clk);
    scroll_only = 1'b1; scroll = 7'h7E; addr = 15'h7777; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_ready(ok);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (busy_m !== 1'b1 || data_ready_m !== 1'b1) begin errors++; $display("FAIL busy_start_state: got busy=%b ready=%b want 1 1", busy_m, data_ready_m); end
    push(8'h99, 1'b1, ok);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_done: got timeout want done"); end
    exp = '{8'h33, 8'h04, 8'h04, 8'h99};
    checks++; if (wire_q.size() - wb != exp.size()) begin errors++; $display("FAIL busy_count: got %0d want %0d", wire_q.size() - wb, exp.size()); end
    foreach (exp[i]) if (wb + i < wire_q.size()) begin
      checks++; if (wire_q[wb+i] !== exp[i]) begin errors++; $display("FAIL busy_byte%0d: got %h want %h", i, wire_q[wb+i], exp[i]); end
    end
    checks++; if (char_mem[14'h0202] !== 8'h99) begin errors++; $display("FAIL busy_char: got %h want 99", char_mem[14'h0202]); end
  endtask

  task automatic test_back_to_back;
    int wb; bit ok;
    wb = wire_q.size();
    kick(1'b1, 7'h11, 15'h0000);
    wait_done(ok);
    scroll_only = 1'b1; scroll = 7'h2A; start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (busy_m !== 1'b1 || ssel_m !== 1'b0) begin errors++; $display("FAIL b2b_accept: got busy=%b ssel=%b want 1 0", busy_m, ssel_m); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done: got timeout want done"); end
    checks++; if (wire_q.size() - wb != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", wire_q.size() - wb); end
    else begin
      checks++; if (wire_q[wb] !== 8'h11 || wire_q[wb+1] !== 8'h2A) begin errors++; $display("FAIL b2b_bytes: got %h %h want 11 2a", wire_q[wb], wire_q[wb+1]); end
    end
  endtask

  task automatic test_reset_mid;
    int wb, rb; bit ok; logic [7:0] exp[$];
    rb = sck_rises;
    kick(1'b0, 7'h22, 15'h2468);
    for (int i = 0; i < 400; i++) begin
      if (sck_rises - rb >= 11) break;
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (ssel_m !== 1'b1 || sck_m !== 1'b0) begin errors++; $display("FAIL rstmid_lines: got ssel=%b sck=%b want 1 0", ssel_m, sck_m); end
    checks++; if (busy_m !== 1'b0 || mosi_m !== 1'b0) begin errors++; $display("FAIL rstmid_busy_mosi: got busy=%b mosi=%b want 0 0", busy_m, mosi_m); end
    @(negedge clk); rst = 1'b0;
    wb = wire_q.size();
    kick(1'b0, 7'h0A, 15'h0002);
    push(8'h33, 1'b1, ok);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_done: got timeout want done"); end
    exp = '{8'h0A, 8'h00, 8'h02, 8'h33};
    checks++; if (wire_q.size() - wb != exp.size()) begin errors++; $display("FAIL rstmid_count: got %0d want %0d", wire_q.size() - wb, exp.size()); end
    foreach (exp[i]) if (wb + i < wire_q.size()) begin
      checks++; if (wire_q[wb+i] !== exp[i]) begin errors++; $display("FAIL rstmid_byte%0d: got %h want %h", i, wire_q[wb+i], exp[i]); end
    end
    checks++; if (char_mem[14'h0001] !== 8'h33) begin errors++; $display("FAIL rstmid_char: got %h want 33", char_mem[14'h0001]); end
  endtask

  task automatic test_div1;
    int wb, mb; bit ok; logic [7:0] exp[$];
    sel = 1'b1;
    wb = wire_q.size(); mb = mv_cnt;
    kick(1'b0, 7'h05, 15'h7FFF);
    push(8'hC3, 1'b0, ok);
    push(8'h5A, 1'b0, ok);
    push(8'hE7, 1'b1, ok);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL div1_done: got timeout want done"); end
    exp = '{8'h05, 8'h7F, 8'hFF, 8'hC3, 8'h5A, 8'hE7};
    checks++; if (wire_q.size() - wb != exp.size()) begin errors++; $display("FAIL div1_count: got %0d want %0d", wire_q.size() - wb, exp.size()); end
    foreach (exp[i]) if (wb + i < wire_q.size()) begin
      checks++; if (wire_q[wb+i] !== exp[i]) begin errors++; $display("FAIL div1_byte%0d: got %h want %h", i, wire_q[wb+i], exp[i]); end
    end
    checks++; if (rise_t - prev_rise_t != 20) begin errors++; $display("FAIL div1_sck_period: got %0t want 20", rise_t - prev_rise_t); end
    checks++; if (mv_cnt - mb != 6) begin errors++; $display("FAIL div1_miso_valid: got %0d want 6", mv_cnt - mb); end
    checks++; if (attr_mem[14'h3FFF] !== 8'hC3 || char_mem[14'h0000] !== 8'h5A || attr_mem[14'h0000] !== 8'hE7) begin
      errors++; $display("FAIL div1_mem: got %h %h %h want c3 5a e7", attr_mem[14'h3FFF], char_mem[14'h0000], attr_mem[14'h0000]);
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; start = 1'b0; scroll_only = 1'b0; scroll = 7'h00; addr = 15'h0000;
    data_in = 8'h00; data_last = 1'b0; data_valid = 1'b0;
    test_reset;
    test_scroll_only;
    test_write;
    test_stall;
    test_start_busy;
    test_back_to_back;
    test_reset_mid;
    test_div1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/textmode_spi_host.md
Name: textmode_spi_host

Overview:
- SPI master that drives the text-mode board's write port over SCK/MOSI/MISO/SSEL. Used by a test harness or soft-CPU on a second FPGA.
- Emits the board's transaction format:
  - byte 0: scroll
  - byte 1: address high (7 bits)
  - byte 2: address low
  - then a streamed run of char/attr data bytes, auto-incremented by the slave
- Also captures the byte returned on MISO for link checking. The slave returns constant 0xA0.

Parameters:
- CLK_DIV, 4: clk cycles per SCK half-period. Legal range is 1 or more.
- CS_GAP, 2: minimum clk cycles SSEL stays high after a transaction before busy drops.

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a transaction; sampled only in IDLE
- scroll_only  in  1  sampled with start; 1 = send byte 0 only
- scroll  in  7  Y scroll value, latched at start
- addr  in  15  start address, latched at start; addr[0]=0 char plane, 1 attr plane
- data_in  in  8  data byte
- data_last  in  1  marks final data byte; sampled with data_in
- data_valid  in  1  data_in is valid
- data_ready  out  1  block will accept data_in this cycle
- busy  out  1  high from start acceptance until end of GAP
- done  out  1  one-cycle pulse when returning to IDLE
- miso_byte  out  8  last byte shifted in from MISO
- miso_valid  out  1  one-cycle pulse when miso_byte updates
- SCK  out  1  serial clock; idles low
- MOSI  out  1  serial data, MSB first
- MISO  in  1  serial data from slave
- SSEL  out  1  active-low select; idles high

Behaviour:
- Reset (asynchronous, any time including mid-byte):
  - SSEL=1, SCK=0, MOSI=0.
  - busy, done, data_ready, miso_valid = 0; miso_byte=0x00.
  - State goes to IDLE.
  - The slave resets its bit counter and state on SSEL high, so an aborted transfer leaves it clean.
- All outputs are registered.
- States: IDLE, SHIFT, WAIT_DATA, HOLD, GAP.
- IDLE:
  - On an edge with start=1:
    - Latch scroll, addr and scroll_only.
    - Load shift register with {1'b0, scroll}.
    - Set byte index=0.
    - Drive SSEL=0 and MOSI=bit 7 on that same edge.
    - Set busy=1 and go to SHIFT.
  - start while busy is ignored.
- SHIFT, per bit:
  - SCK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - On the rising SCK edge: sample MISO into the receive shift register.
  - On the falling SCK edge: MOSI advances to the next bit.
  - One byte = 16*CLK_DIV cycles. MOSI is stable across every SCK rise.
- At the falling edge ending each byte:
  - miso_byte <= received byte; miso_valid pulses for 1 cycle.
  - Next byte:
    - after byte 0 with scroll_only=1: go to HOLD
    - after byte 0 otherwise: send {1'b0, addr[14:8]}
    - after byte 1: send addr[7:0]
    - after byte 2, or after a data byte with last=0: go to WAIT_DATA
    - after a data byte with last=1: go to HOLD
- Header bytes are back-to-back. There is no extra SCK-low time between bytes.
- WAIT_DATA:
  - data_ready=1, SCK held low, SSEL held low. The stall length is unbounded; the slave is edge-driven.
  - On an edge with data_valid & data_ready:
    - Latch data_in and data_last.
    - MOSI=data_in[7], data_ready=0.
    - Go to SHIFT.
  - data_ready is 0 in every other state.
- HOLD: SCK low, SSEL low for CLK_DIV cycles, then SSEL=1 and go to GAP.
- GAP:
  - SSEL high for CS_GAP cycles.
  - Then busy=0, done=1 for 1 cycle, go to IDLE.
  - A start coinciding with the done pulse is accepted, since IDLE is entered on that edge and sampled on the next.
- Counters:
  - Half-period counter width is clog2(CLK_DIV+1) and wraps at CLK_DIV-1.
  - Bit counter is 3 bits and counts down 7 to 0.
- The slave auto-increments the address. The host does not track it.

Test Plan:
- scroll_only=1, scroll=0x15, CLK_DIV=4:
  - MOSI bits on SCK rises = 0x15.
  - Exactly 8 SCK pulses.
  - SSEL low for 64+4 cycles.
  - done 2+1 cycles after SSEL rises.
  - miso_byte=0xA0 from the slave model.
- scroll=0x7F, addr=0x1234, data 0x41 then 0x1E with last on 0x1E:
  - Bytes on wire: 7F 12 34 41 1E.
  - Slave model writes 0x41 to char[0x091A] and 0x1E to attr[0x091A].
- data_valid withheld 50 cycles after header:
  - SCK stays low and SSEL stays low for the whole stall.
  - Transfer resumes on the first handshake with correct bytes.
- rst asserted mid-byte 1:
  - SSEL=1 and SCK=0 immediately, without waiting for a clk edge.
  - A new transaction then completes correctly with the slave model.
- start pulsed while busy:
  - Ignored; latched scroll/addr unchanged; byte count unchanged.
- CLK_DIV=1, addr=0x7FFF, 3 data bytes:
  - SCK period = 2 cycles.
  - Header bytes FF-masked to 7F FF.
  - miso_valid pulses 6 times.
